// File: rtl/game_tick_sequencer.sv
// rtl/game_tick_sequencer.sv - per-tick ghost collision / dot eat sequencer and game state owner
module game_tick_sequencer #(
  parameter int XW             = 10,
  parameter int YW             = 9,
  parameter int TILE_SIZE      = 16,
  parameter int TILE_COLS      = 40,
  parameter int AW             = 11,
  parameter int SCORE_W        = 20,
  parameter int MAX_DOTS       = 300,
  parameter int POWER_TIME     = 10,
  parameter int DOT_POINTS     = 10,
  parameter int BIGDOT_POINTS  = 50,
  parameter int GHOST_POINTS   = 200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic [XW-1:0]      player_x,
  input  logic [YW-1:0]      player_y,
  input  logic [4*XW-1:0]    ghost_x,
  input  logic [4*YW-1:0]    ghost_y,
  output logic [AW-1:0]      dot_addr,
  input  logic [1:0]         dot_rd_data,
  output logic               dot_wr_en,
  output logic [3:0]         ghost_respawn,
  output logic [3:0]         ghost_move_en,
  output logic [2:0]         game_state,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               done
);

  localparam int TS    = $clog2(TILE_SIZE);
  localparam int ATE_W = $clog2(MAX_DOTS + 1);
  localparam int PW    = $clog2(POWER_TIME + 1);

  localparam logic [2:0] GS_STANDBY  = 3'd0;
  localparam logic [2:0] GS_PLAYING  = 3'd1;
  localparam logic [2:0] GS_POWER    = 3'd2;
  localparam logic [2:0] GS_GAMEOVER = 3'd3;
  localparam logic [2:0] GS_WIN      = 3'd4;

  localparam logic signed [XW:0] TSX  = (XW+1)'(TILE_SIZE);
  localparam logic signed [XW:0] NTSX = -TSX;
  localparam logic signed [YW:0] TSY  = (YW+1)'(TILE_SIZE);
  localparam logic signed [YW:0] NTSY = -TSY;

  localparam logic [SCORE_W:0] DOT_INC   = (SCORE_W+1)'(DOT_POINTS);
  localparam logic [SCORE_W:0] BIG_INC   = (SCORE_W+1)'(BIGDOT_POINTS);
  localparam logic [SCORE_W:0] GHOST_INC = (SCORE_W+1)'(GHOST_POINTS);
  localparam logic [ATE_W-1:0] MAX_ATE   = ATE_W'(MAX_DOTS);
  localparam logic [PW-1:0]    PT        = PW'(POWER_TIME);

  typedef enum logic [2:0] {
    S_IDLE, S_C0, S_C1, S_C2, S_C3, S_DOT_RD, S_DOT_EVAL, S_FINISH
  } seq_t;

  seq_t              seq_q, seq_d;
  logic [XW-1:0]     px_q;
  logic [YW-1:0]     py_q;
  logic [4*XW-1:0]   gx_q;
  logic [4*YW-1:0]   gy_q;
  logic [3:0]        respawned_q;
  logic              bigdot_q;
  logic [ATE_W-1:0]  ate_q;
  logic [PW-1:0]     pcnt_q;
  logic [3:0]        coll;
  logic [1:0]        gidx;
  logic              in_check;
  logic              hit;
  logic              abort;
  logic              eat;
  logic [AW-1:0]     tile_addr;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W:0]   inc);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + inc;
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  // Overlap test per ghost against the snapshotted player position (signed distance).
  for (genvar g = 0; g < 4; g++) begin : g_coll
    logic signed [XW:0] dx;
    logic signed [YW:0] dy;
    assign dx = $signed({1'b0, gx_q[g*XW +: XW]}) - $signed({1'b0, px_q});
    assign dy = $signed({1'b0, gy_q[g*YW +: YW]}) - $signed({1'b0, py_q});
    assign coll[g] = (dx < TSX) && (dx > NTSX) && (dy < TSY) && (dy > NTSY);
  end

  assign tile_addr = AW'(py_q >> TS) * AW'(TILE_COLS) + AW'(px_q >> TS);

  // Select which ghost the current check state is looking at.
  always_comb begin
    in_check = 1'b1;
    gidx     = 2'd0;
    case (seq_q)
      S_C0:    gidx = 2'd0;
      S_C1:    gidx = 2'd1;
      S_C2:    gidx = 2'd2;
      S_C3:    gidx = 2'd3;
      default: in_check = 1'b0;
    endcase
  end

  assign hit   = in_check && coll[gidx];
  assign abort = hit && (game_state == GS_PLAYING);
  assign eat   = (seq_q == S_DOT_EVAL) && ((dot_rd_data == 2'b01) || (dot_rd_data == 2'b10));

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) seq_q <= S_IDLE;
    else       seq_q <= seq_d;
  end

  // Sequencer next state: a fatal collision jumps straight to FINISH.
  always_comb begin
    seq_d = seq_q;
    case (seq_q)
      S_IDLE:     if (tick && ((game_state == GS_PLAYING) || (game_state == GS_POWER))) seq_d = S_C0;
      S_C0:       seq_d = abort ? S_FINISH : S_C1;
      S_C1:       seq_d = abort ? S_FINISH : S_C2;
      S_C2:       seq_d = abort ? S_FINISH : S_C3;
      S_C3:       seq_d = abort ? S_FINISH : S_DOT_RD;
      S_DOT_RD:   seq_d = S_DOT_EVAL;
      S_DOT_EVAL: seq_d = S_FINISH;
      S_FINISH:   seq_d = S_IDLE;
      default:    seq_d = S_IDLE;
    endcase
  end

  // Sequencer outputs; ghosts eaten this sequence are held back from moving.
  always_comb begin
    busy          = (seq_q != S_IDLE);
    done          = (seq_q == S_FINISH);
    dot_wr_en     = eat;
    ghost_move_en = 4'b0000;
    if ((seq_q == S_FINISH) && (game_state != GS_GAMEOVER)) ghost_move_en = ~respawned_q;
  end

  // Game datapath: snapshot, score, dot count, power countdown and game state.
  always_ff @(posedge clk) begin
    if (reset) begin
      game_state    <= GS_STANDBY;
      score         <= '0;
      ate_q         <= '0;
      pcnt_q        <= '0;
      dot_addr      <= '0;
      ghost_respawn <= '0;
      respawned_q   <= '0;
      bigdot_q      <= 1'b0;
      px_q          <= '0;
      py_q          <= '0;
      gx_q          <= '0;
      gy_q          <= '0;
    end else begin
      ghost_respawn <= '0;
      if ((seq_q == S_IDLE) && tick) begin
        if ((game_state == GS_STANDBY) && start) begin
          game_state <= GS_PLAYING;
        end else if ((game_state == GS_PLAYING) || (game_state == GS_POWER)) begin
          px_q        <= player_x;
          py_q        <= player_y;
          gx_q        <= ghost_x;
          gy_q        <= ghost_y;
          respawned_q <= '0;
          bigdot_q    <= 1'b0;
        end
      end
      if (hit) begin
        if (game_state == GS_POWER) begin
          ghost_respawn[gidx] <= 1'b1;
          respawned_q[gidx]   <= 1'b1;
          score               <= sat_add(score, GHOST_INC);
        end else if (game_state == GS_PLAYING) begin
          game_state <= GS_GAMEOVER;
        end
      end
      if ((seq_q == S_C3) && !abort) dot_addr <= tile_addr;
      if (eat) begin
        score <= sat_add(score, (dot_rd_data == 2'b10) ? BIG_INC : DOT_INC);
        if (ate_q < MAX_ATE) ate_q <= ate_q + 1'b1;
        if (dot_rd_data == 2'b10) begin
          pcnt_q     <= PT;
          game_state <= GS_POWER;
          bigdot_q   <= 1'b1;
        end
      end
      if ((seq_q == S_FINISH) && (game_state != GS_GAMEOVER)) begin
        if (ate_q == MAX_ATE) begin
          game_state <= GS_WIN;
        end else if ((game_state == GS_POWER) && !bigdot_q) begin
          if (pcnt_q != '0) pcnt_q     <= pcnt_q - 1'b1;
          else              game_state <= GS_PLAYING;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_tick_sequencer.sv
// tb/tb_game_tick_sequencer.sv - self-checking bench for game_tick_sequencer
module tb_game_tick_sequencer;
  localparam int XW = 10, YW = 9, AW = 11, SCORE_W = 20, MAX_DOTS = 300;

  logic               clk = 1'b0;
  logic               reset, tick, start;
  logic [XW-1:0]      player_x;
  logic [YW-1:0]      player_y;
  logic [4*XW-1:0]    ghost_x;
  logic [4*YW-1:0]    ghost_y;
  logic [AW-1:0]      dot_addr;
  logic [1:0]         dot_rd_data;
  logic               dot_wr_en;
  logic [3:0]         ghost_respawn, ghost_move_en;
  logic [2:0]         game_state;
  logic [SCORE_W-1:0] score;
  logic               busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // per-cycle output vector {busy, done, dot_wr_en, respawn[3:0], move_en[3:0]}
  logic [10:0]   obs   [1:10];
  logic [10:0]   exp_v [1:10];
  logic [AW-1:0] addr5;

  // reference model state
  int         m_state, m_ate, m_pcnt;
  longint     m_score;
  logic [1:0] mem [1200];
  int         px_i, py_i;
  int         gx_i [4];
  int         gy_i [4];
  int         e_addr;
  logic [1:0] e_rd;
  bit         e_seq, e_abort;

  typedef struct {
    int              px;
    int              py;
    logic [4*XW-1:0] gx;
    logic [4*YW-1:0] gy;
    logic [1:0]      rd;
    int              st;
    int              dn;
    logic [3:0]      mv;
    int              sc;
    bit              wr;
    int              addr;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  game_tick_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .player_x(player_x), .player_y(player_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .dot_addr(dot_addr), .dot_rd_data(dot_rd_data), .dot_wr_en(dot_wr_en),
    .ghost_respawn(ghost_respawn), .ghost_move_en(ghost_move_en),
    .game_state(game_state), .score(score), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; tick = 1'b0; start = 1'b0; dot_rd_data = 2'b11;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic go_playing();
    start = 1'b1;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_pos(input int px, input int py, input logic [4*XW-1:0] gx, input logic [4*YW-1:0] gy);
    player_x = px[XW-1:0];
    player_y = py[YW-1:0];
    ghost_x  = gx;
    ghost_y  = gy;
  endtask

  // Pulse tick in cycle T, record outputs for T+1..T+10; the RAM answer is presented for T+6.
  task automatic run_tick(input logic [1:0] rd_val, input bit extra);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      obs[k] = {busy, done, dot_wr_en, ghost_respawn, ghost_move_en};
      if (k == 3 && extra) tick = 1'b1;
      if (k == 4) tick = 1'b0;
      if (k == 5) begin addr5 = dot_addr; dot_rd_data = rd_val; end
      if (k == 7) dot_rd_data = 2'b11;
    end
  endtask

  function automatic bit near(input int a, input int b);
    return (a - b < 16) && (b - a < 16);
  endfunction

  // Behavioural rules for one tick, applied to the model state.
  task automatic model_step();
    logic [3:0] resp;
    int         ab, dk;
    bit         big;
    for (int k = 1; k <= 10; k++) exp_v[k] = '0;
    e_seq = 0; e_abort = 0; e_rd = 2'b11; e_addr = 0;
    if (m_state == 0) begin
      if (start) m_state = 1;
      return;
    end
    if (m_state >= 3) return;
    e_seq = 1; resp = 4'b0; ab = -1; big = 0;
    for (int i = 0; i < 4; i++) begin
      if (ab < 0 && near(gx_i[i], px_i) && near(gy_i[i], py_i)) begin
        if (m_state == 2) begin
          resp[i] = 1'b1;
          m_score = m_score + 200;
          exp_v[i+2][4+i] = 1'b1;
        end else ab = i;
      end
    end
    dk = (ab >= 0) ? ab + 2 : 7;
    for (int k = 1; k <= dk; k++) exp_v[k][10] = 1'b1;
    exp_v[dk][9] = 1'b1;
    if (ab >= 0) begin
      m_state = 3; e_abort = 1;
    end else begin
      e_addr = (py_i / 16) * 40 + px_i / 16;
      e_rd   = mem[e_addr];
      if (e_rd == 2'b01 || e_rd == 2'b10) begin
        exp_v[6][8] = 1'b1;
        m_score = m_score + ((e_rd == 2'b01) ? 10 : 50);
        if (m_ate < MAX_DOTS) m_ate++;
        mem[e_addr] = 2'b00;
        if (e_rd == 2'b10) begin big = 1; m_pcnt = 10; m_state = 2; end
      end
      exp_v[7][3:0] = ~resp;
      if (m_ate == MAX_DOTS) m_state = 4;
      else if (m_state == 2 && !big) begin
        if (m_pcnt > 0) m_pcnt--;
        else m_state = 1;
      end
    end
    if (m_score > (longint'(1) << SCORE_W) - 1) m_score = (longint'(1) << SCORE_W) - 1;
  endtask

  initial begin
    int         dk;
    logic [3:0] mv;
    bit         wr, bad, ext;
    logic [10:0] any;
    localparam logic [4*XW-1:0] FARX = {4{10'd620}};
    localparam logic [4*YW-1:0] FARY = {4{9'd460}};

    vecs[0] = '{100, 100, {10'd620, 10'd620, 10'd620, 10'd110}, {9'd460, 9'd460, 9'd460, 9'd92},  2'b00, 3, 2, 4'h0, 0,  0, 0};
    vecs[1] = '{200, 200, {10'd620, 10'd620, 10'd216, 10'd620}, {9'd460, 9'd460, 9'd200, 9'd460}, 2'b00, 1, 7, 4'hF, 0,  0, 492};
    vecs[2] = '{200, 200, {10'd620, 10'd620, 10'd185, 10'd620}, {9'd460, 9'd460, 9'd215, 9'd460}, 2'b00, 3, 3, 4'h0, 0,  0, 0};
    vecs[3] = '{35,  50,  FARX, FARY,                                                              2'b01, 1, 7, 4'hF, 10, 1, 122};
    vecs[4] = '{35,  50,  FARX, FARY,                                                              2'b10, 2, 7, 4'hF, 50, 1, 122};
    vecs[5] = '{35,  50,  FARX, FARY,                                                              2'b11, 1, 7, 4'hF, 0,  0, 122};
    vecs[6] = '{300, 300, {10'd315, 10'd620, 10'd620, 10'd620}, {9'd285, 9'd460, 9'd460, 9'd460}, 2'b00, 3, 5, 4'h0, 0,  0, 0};

    tick = 0; start = 0; reset = 1; dot_rd_data = 2'b11;
    set_pos(0, 0, FARX, FARY);

    // reset state and STANDBY handling
    reset_dut();
    @(negedge clk);
    check("rst_state", game_state, 0);
    check("rst_score", score, 0);
    check("rst_outs", {busy, done, dot_wr_en, ghost_respawn, ghost_move_en, dot_addr}, 0);
    run_tick(2'b11, 0);
    any = '0;
    for (int k = 1; k <= 10; k++) any |= obs[k];
    check("standby_nostart_outs", any, 0);
    check("standby_nostart_state", game_state, 0);
    start = 1'b1;
    run_tick(2'b11, 0);
    start = 1'b0;
    any = '0;
    for (int k = 1; k <= 10; k++) any |= obs[k];
    check("standby_start_outs", any, 0);
    check("standby_start_state", game_state, 1);

    // table of single-tick vectors, each from a fresh PLAYING state
    for (int v = 0; v < 7; v++) begin
      reset_dut();
      go_playing();
      set_pos(vecs[v].px, vecs[v].py, vecs[v].gx, vecs[v].gy);
      run_tick(vecs[v].rd, 0);
      dk = 0; wr = 0;
      for (int k = 1; k <= 10; k++) begin
        if (dk == 0 && obs[k][9]) dk = k;
        if (obs[k][8]) wr = 1;
      end
      mv = (dk > 0) ? obs[dk][3:0] : 4'hx;
      check($sformatf("vec%0d_state", v), game_state, vecs[v].st);
      check($sformatf("vec%0d_done_at", v), dk, vecs[v].dn);
      check($sformatf("vec%0d_move_en", v), mv, vecs[v].mv);
      check($sformatf("vec%0d_score", v), score, vecs[v].sc);
      check($sformatf("vec%0d_wr", v), wr, vecs[v].wr);
      if (vecs[v].dn == 7) check($sformatf("vec%0d_addr", v), addr5, vecs[v].addr);
    end

    // big dot, ghost eaten in power mode, power expiry
    reset_dut();
    go_playing();
    set_pos(35, 50, FARX, FARY);
    run_tick(2'b10, 0);
    check("pwr_state", game_state, 2);
    ghost_x[2*XW +: XW] = 10'd40;
    ghost_y[2*YW +: YW] = 9'd55;
    run_tick(2'b00, 0);
    check("pwr_resp_c3", obs[3][7:4], 4'b0000);
    check("pwr_resp_c4", obs[4][7:4], 4'b0100);
    check("pwr_resp_c5", obs[5][7:4], 4'b0000);
    check("pwr_move_en", obs[7][3:0], 4'b1011);
    check("pwr_ghost_score", score, 250);
    set_pos(35, 50, FARX, FARY);
    for (int t = 2; t <= 11; t++) begin
      run_tick(2'b00, 0);
      if (t == 10) check("pwr_still_t10", game_state, 2);
      if (t == 11) check("pwr_expire_t11", game_state, 1);
    end

    // eat up to the win threshold, then ticks are ignored
    reset_dut();
    go_playing();
    set_pos(35, 50, FARX, FARY);
    for (int t = 0; t < MAX_DOTS - 1; t++) run_tick(2'b01, 0);
    check("win_pre_score", score, 10 * (MAX_DOTS - 1));
    check("win_pre_state", game_state, 1);
    run_tick(2'b01, 0);
    check("win_state", game_state, 4);
    check("win_wr", obs[6][8], 1);
    run_tick(2'b01, 0);
    any = '0;
    for (int k = 1; k <= 10; k++) any |= obs[k];
    check("win_ignore_outs", any, 0);
    check("win_ignore_score", score, 10 * MAX_DOTS);

    // reset in the middle of a sequence
    reset_dut();
    go_playing();
    set_pos(35, 50, FARX, FARY);
    dot_rd_data = 2'b01;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    bad = 0;
    for (int k = 4; k <= 9; k++) begin
      if (dot_wr_en || done || busy) bad = 1;
      @(negedge clk);
    end
    check("rst_abort_quiet", bad, 0);
    check("rst_abort_state", game_state, 0);
    check("rst_abort_score", score, 0);
    dot_rd_data = 2'b11;

    // randomized ticks against the reference model
    reset_dut();
    m_state = 0; m_score = 0; m_ate = 0; m_pcnt = 0;
    for (int i = 0; i < 1200; i++) mem[i] = 2'($urandom_range(3, 0));
    for (int it = 0; it < 200; it++) begin
      start = 1'($urandom_range(1, 0));
      px_i = int'($urandom_range(570, 60));
      py_i = int'($urandom_range(410, 60));
      player_x = px_i[XW-1:0];
      player_y = py_i[YW-1:0];
      for (int i = 0; i < 4; i++) begin
        gx_i[i] = px_i + int'($urandom_range(120, 0)) - 60;
        gy_i[i] = py_i + int'($urandom_range(120, 0)) - 60;
        ghost_x[i*XW +: XW] = gx_i[i][XW-1:0];
        ghost_y[i*YW +: YW] = gy_i[i][YW-1:0];
      end
      model_step();
      ext = e_seq && !e_abort && ($urandom_range(1, 0) == 1);
      run_tick((e_seq && !e_abort) ? e_rd : 2'b11, ext);
      for (int k = 1; k <= 10; k++) check($sformatf("rnd%0d_cyc%0d", it, k), obs[k], exp_v[k]);
      if (e_seq && !e_abort) check($sformatf("rnd%0d_addr", it), addr5, e_addr);
      check($sformatf("rnd%0d_state", it), game_state, m_state);
      check($sformatf("rnd%0d_score", it), score, m_score);
      if ((m_state == 3 || m_state == 4) && $urandom_range(2, 0) == 0) begin
        reset_dut();
        m_state = 0; m_score = 0; m_ate = 0; m_pcnt = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
